// File: rtl/pll_cfg_seq.sv
// PLL apply sequencer: bypass -> load settings -> settle -> release; done two cycles after RELEASE is entered.
// Latency start->done is SETTLE_CYCLES+4; stop aborts to bypass/PLL-off. PLL_LOCK_CHECK_EN adds a timed lock wait.
module pll_cfg_seq #(
  parameter logic [15:0] SETTLE_CYCLES = 16'd64,
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [25:0] cfg_trim,
  input  logic [4:0]  cfg_div,
  input  logic [5:0]  cfg_sel,
  input  logic        cfg_bypass,
  input  logic        pll_lock,
  output logic        pll_ena,
  output logic        pll_dco_ena,
  output logic        pll_bypass,
  output logic [25:0] pll_trim,
  output logic [4:0]  pll_div,
  output logic [5:0]  pll_sel,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef PLL_LOCK_CHECK_EN
  typedef enum logic [2:0] {IDLE, BYPASS, LOAD, SETTLE, RELEASE, LOCKWAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, BYPASS, LOAD, SETTLE, RELEASE} state_t;
  logic unused_lock;
  assign unused_lock = pll_lock | (LOCK_TIMEOUT == 16'd0);
`endif

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [25:0] sh_trim, sh_trim_nxt, trim_nxt;
  logic [4:0]  sh_div, sh_div_nxt, div_nxt;
  logic [5:0]  sh_sel, sh_sel_nxt, sel_nxt;
  logic        sh_byp, sh_byp_nxt;
  logic        ena_nxt, dco_nxt, byp_nxt, busy_nxt, done_nxt, err_nxt;
  // fin marks sequence completion; done follows it by one cycle
  logic        fin, fin_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_trim_nxt = sh_trim;
    sh_div_nxt  = sh_div;
    sh_sel_nxt  = sh_sel;
    sh_byp_nxt  = sh_byp;
    trim_nxt    = pll_trim;
    div_nxt     = pll_div;
    sel_nxt     = pll_sel;
    ena_nxt     = pll_ena;
    dco_nxt     = pll_dco_ena;
    byp_nxt     = pll_bypass;
    busy_nxt    = busy;
    err_nxt     = err;
    fin_nxt     = 1'b0;
    done_nxt    = fin;
    if (stop) begin
      state_nxt = IDLE;
      byp_nxt   = 1'b1;
      ena_nxt   = 1'b0;
      dco_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt   = BYPASS;
          busy_nxt    = 1'b1;
          err_nxt     = 1'b0;
          sh_trim_nxt = cfg_trim;
          sh_div_nxt  = cfg_div;
          sh_sel_nxt  = cfg_sel;
          sh_byp_nxt  = cfg_bypass;
        end
        BYPASS: begin
          byp_nxt   = 1'b1;
          state_nxt = LOAD;
        end
        LOAD: begin
          trim_nxt  = sh_trim;
          div_nxt   = sh_div;
          sel_nxt   = sh_sel;
          ena_nxt   = 1'b1;
          dco_nxt   = 1'b1;
          cnt_nxt   = SETTLE_CYCLES - 16'd1;
          state_nxt = SETTLE;
        end
        SETTLE: if (cnt == 16'd0) begin
`ifdef PLL_LOCK_CHECK_EN
          cnt_nxt   = LOCK_TIMEOUT - 16'd1;
          state_nxt = LOCKWAIT;
`else
          state_nxt = RELEASE;
`endif
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
        RELEASE: begin
          byp_nxt   = sh_byp;
          busy_nxt  = 1'b0;
          fin_nxt   = 1'b1;
          state_nxt = IDLE;
        end
`ifdef PLL_LOCK_CHECK_EN
        // timeout leaves the core on the external clock with the PLL off
        LOCKWAIT: if (pll_lock) begin
          state_nxt = RELEASE;
        end else if (cnt == 16'd0) begin
          err_nxt   = 1'b1;
          byp_nxt   = 1'b1;
          ena_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          fin_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      sh_trim     <= 26'd0;
      sh_div      <= 5'd0;
      sh_sel      <= 6'd0;
      sh_byp      <= 1'b1;
      pll_trim    <= 26'h3ffefff;
      pll_div     <= 5'h12;
      pll_sel     <= 6'h04;
      pll_ena     <= 1'b0;
      pll_dco_ena <= 1'b1;
      pll_bypass  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      fin         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sh_trim     <= sh_trim_nxt;
      sh_div      <= sh_div_nxt;
      sh_sel      <= sh_sel_nxt;
      sh_byp      <= sh_byp_nxt;
      pll_trim    <= trim_nxt;
      pll_div     <= div_nxt;
      pll_sel     <= sel_nxt;
      pll_ena     <= ena_nxt;
      pll_dco_ena <= dco_nxt;
      pll_bypass  <= byp_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      fin         <= fin_nxt;
    end
  end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq (default build): expected outputs are derived per cycle from the
// sequence timeline (cycles since start, stop point), with randomized cfg inputs.
module tb_pll_cfg_seq;
  localparam int S = 64;

  logic        clock = 1'b0;
  logic        reset, start, stop, cfg_bypass, pll_lock;
  logic [25:0] cfg_trim;
  logic [4:0]  cfg_div;
  logic [5:0]  cfg_sel;
  logic        pll_ena, pll_dco_ena, pll_bypass, busy, done, err;
  logic [25:0] pll_trim;
  logic [4:0]  pll_div;
  logic [5:0]  pll_sel;

  always #5 clock = ~clock;

  pll_cfg_seq #(.SETTLE_CYCLES(16'(S)), .LOCK_TIMEOUT(16'd1024)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .cfg_trim(cfg_trim), .cfg_div(cfg_div), .cfg_sel(cfg_sel), .cfg_bypass(cfg_bypass),
    .pll_lock(pll_lock), .pll_ena(pll_ena), .pll_dco_ena(pll_dco_ena), .pll_bypass(pll_bypass),
    .pll_trim(pll_trim), .pll_div(pll_div), .pll_sel(pll_sel),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic busy, done, err, byp, ena, dco;
    logic [25:0] trim;
    logic [4:0]  div;
    logic [5:0]  sel;
  } obs_t;

  typedef struct packed {
    logic [25:0] trim;
    logic [4:0]  div;
    logic [5:0]  sel;
    logic        byp;
  } cfg_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t expv;

  function automatic obs_t rst_val();
    obs_t r;
    r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0;
    r.byp = 1'b1;  r.ena = 1'b0;  r.dco = 1'b1;
    r.trim = 26'h3ffefff; r.div = 5'h12; r.sel = 6'h04;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.err = err;
    o.byp = pll_bypass; o.ena = pll_ena; o.dco = pll_dco_ena;
    o.trim = pll_trim; o.div = pll_div; o.sel = pll_sel;
    return o;
  endfunction

  function automatic cfg_t mk_cfg(logic [25:0] t, logic [4:0] d, logic [5:0] s, logic b);
    cfg_t c;
    c.trim = t; c.div = d; c.sel = s; c.byp = b;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    return mk_cfg(26'($urandom), 5'($urandom), 6'($urandom), 1'($urandom));
  endfunction

  task automatic set_cfg(input cfg_t c);
    cfg_trim = c.trim; cfg_div = c.div; cfg_sel = c.sel; cfg_bypass = c.byp;
  endtask

  // Outputs k edges after the edge that samples start (k=0 is that edge).
  // Timeline: bypass forced at k=1, settings/enables at k=2, S settle cycles,
  // release effective at k=S+3, done pulse at k=S+4. A stop seen at edge stop_k
  // leaves bypass=1, PLL off, idle; settings only if they were already loaded.
  function automatic obs_t model(int k, obs_t prev, cfg_t c, int stop_k);
    obs_t e;
    e = prev;
    e.done = 1'b0;
    e.err  = 1'b0;
    if (stop_k >= 0 && k >= stop_k) begin
      e.busy = 1'b0; e.byp = 1'b1; e.ena = 1'b0; e.dco = 1'b0;
      if (stop_k >= 3) begin
        e.trim = c.trim; e.div = c.div; e.sel = c.sel;
      end
      return e;
    end
    e.busy = (k <= S + 2);
    if (k >= 1) e.byp = (k <= S + 2) ? 1'b1 : c.byp;
    if (k >= 2) begin
      e.trim = c.trim; e.div = c.div; e.sel = c.sel;
      e.ena = 1'b1; e.dco = 1'b1;
    end
    e.done = (k == S + 4);
    return e;
  endfunction

  task automatic test_reset();
    obs_t got;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pll_lock = 1'b0;
    set_cfg(rand_cfg());
    #12;
    got = sample();
    vectors++;
    if (got !== rst_val()) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", got, rst_val());
    end
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    got = sample();
    vectors++;
    if (got !== rst_val()) begin
      miscompares++;
      $display("FAIL reset_start_ignored got=%h want=%h", got, rst_val());
    end
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      got = sample();
      vectors++;
      if (got !== rst_val()) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", i, got, rst_val());
      end
    end
    expv = rst_val();
  endtask

  // restart_k >= 0 drives a second start (different cfg) sampled at edge restart_k+1.
  task automatic test_sequence(input string name, input cfg_t c, input int stop_k, input int restart_k);
    obs_t prev, got, want;
    prev = expv;
    want = expv;
    set_cfg(c);
    start = 1'b1;
    stop = (stop_k == 0);
    for (int k = 0; k <= S + 6; k++) begin
      @(posedge clock);
      #1;
      got = sample();
      want = model(k, prev, c, stop_k);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
      end
      set_cfg(rand_cfg());
      start = (k == restart_k);
      stop = (k + 1 == stop_k);
      pll_lock = 1'($urandom);
    end
    start = 1'b0;
    stop = 1'b0;
    expv = want;
  endtask

  task automatic test_apply();
    test_sequence("apply_fixed", mk_cfg(26'h1234567, 5'h0a, 6'h11, 1'b0), -1, -1);
    test_sequence("apply_bypass", mk_cfg(26'($urandom), 5'($urandom), 6'($urandom), 1'b1), -1, -1);
    test_sequence("apply_rand", rand_cfg(), -1, -1);
  endtask

  task automatic test_stop();
    // stop seen right after counter reads 20 in SETTLE; an earlier second start is ignored
    test_sequence("stop_settle20", rand_cfg(), 46, 10);
    test_sequence("start_stop_same", rand_cfg(), 0, -1);
    test_sequence("stop_in_load", rand_cfg(), 2, 0);
    test_sequence("apply_after_stop", mk_cfg(26'($urandom), 5'($urandom), 6'($urandom), 1'b0), -1, -1);
  endtask

  task automatic test_reset_mid(input cfg_t c, input int r);
    obs_t prev, got, want;
    prev = expv;
    set_cfg(c);
    start = 1'b1;
    for (int k = 0; k <= r; k++) begin
      @(posedge clock);
      #1;
      got = sample();
      want = model(k, prev, c, -1);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid_pre k=%0d got=%h want=%h", k, got, want);
      end
      start = 1'b0;
      set_cfg(rand_cfg());
    end
    reset = 1'b1;
    #1;
    got = sample();
    vectors++;
    if (got !== rst_val()) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%h want=%h", got, rst_val());
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < S + 8; i++) begin
      @(posedge clock);
      #1;
      got = sample();
      vectors++;
      if (got !== rst_val()) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", i, got, rst_val());
      end
    end
    expv = rst_val();
  endtask

  task automatic test_back_to_back();
    int sk, rk;
    for (int n = 0; n < 8; n++) begin
      sk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, S + 6));
      rk = int'($urandom_range(0, S + 2));
      if (sk >= 0 && rk + 1 > sk) rk = -1;
      test_sequence("back_to_back", rand_cfg(), sk, rk);
    end
  endtask

  initial begin
    test_reset();
    test_apply();
    test_stop();
    test_reset_mid(rand_cfg(), 30);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
